// File: rtl/trace_pkg.sv
// Shared types for the commit-trace capture block: FSM state encoding and trace entry layout.
// Optional repeat filtering in trace_capture is enabled with TRACE_REPEAT_FILTER_EN.
package trace_pkg;

    localparam int TRACE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Entry layout at the default field width; the RAM stores {pc, inst, data} in this order.
    typedef struct packed {
        logic [TRACE_W-1:0] pc;
        logic [TRACE_W-1:0] inst;
        logic [TRACE_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x DW simple dual-port array with one write port and a registered read port.
// Array contents are never reset; only the read register is.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds the last popped word until the next read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_capture.sv
// Commit-trace capture: records committed instructions into a circular buffer around a pc trigger,
// then drains oldest-first. Define TRACE_REPEAT_FILTER_EN to drop back-to-back repeats of the same pc.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int POST  = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic [W-1:0]           trig_pc,
    input  logic                   cap_valid,
    input  logic [W-1:0]           cap_pc,
    input  logic [W-1:0]           cap_inst,
    input  logic [W-1:0]           cap_data,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [W-1:0]           rd_pc,
    output logic [W-1:0]           rd_inst,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   armed,
    output logic                   triggered,
    output logic                   done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] POST_C  = CW'(POST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   post_cnt_q, post_cnt_d;
    logic            rd_valid_q;
    logic            repeat_s;
    logic            wr_s;
    logic            pop_s;
    logic [AW-1:0]   rd_addr_s;
    logic [3*W-1:0]  rd_word_s;

`ifdef TRACE_REPEAT_FILTER_EN
    logic [W-1:0] last_pc_q;
    logic         last_vld_q;

    assign repeat_s = last_vld_q && (cap_pc == last_pc_q);

    // Remember the pc of the last entry written since arm
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
        end else if (arm) begin
            last_vld_q <= 1'b0;
        end else if (wr_s) begin
            last_pc_q  <= cap_pc;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign repeat_s = 1'b0;
`endif

    assign wr_s      = cap_valid && !arm && !repeat_s &&
                       ((state_q == ST_ARMED) || (state_q == ST_POST));
    assign pop_s     = rd_en && !arm && (state_q == ST_DONE) && (count_q != '0);
    assign rd_addr_s = wr_ptr_q - count_q[AW-1:0];

    // Next-state logic: arm beats capture; pops only happen in DONE where no writes occur
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        if (arm) begin
            state_d    = ST_ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
        end else if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = (count_q == DEPTH_C) ? count_q : (count_q + CNT_ONE);
            if (state_q == ST_ARMED) begin
                if (cap_pc == trig_pc) begin
                    post_cnt_d = POST_C;
                    state_d    = (POST_C == '0) ? ST_DONE : ST_POST;
                end else begin
                    state_d = ST_ARMED;
                end
            end else begin
                post_cnt_d = post_cnt_q - CNT_ONE;
                state_d    = (post_cnt_q == CNT_ONE) ? ST_DONE : ST_POST;
            end
        end else if (pop_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            state_d = state_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            rd_valid_q <= pop_s;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .DW    (3 * W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_s),
        .waddr_i (wr_ptr_q),
        .wdata_i ({cap_pc, cap_inst, cap_data}),
        .re_i    (pop_s),
        .raddr_i (rd_addr_s),
        .rdata_o (rd_word_s)
    );

    assign {rd_pc, rd_inst, rd_data} = rd_word_s;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign armed     = (state_q == ST_ARMED);
    assign triggered = (state_q == ST_POST) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture: one DEPTH=8/POST=2 instance and one DEPTH=8/POST=0
// instance share the stimulus; expected values are hand-derived per scenario.
module tb_trace_capture;

    logic        clk = 1'b0;
    logic        reset, arm, cap_valid, rd_en;
    logic [31:0] trig_pc, cap_pc, cap_inst, cap_data;

    logic        rd_valid, armed, triggered, done;
    logic [31:0] rd_pc, rd_inst, rd_data;
    logic [3:0]  count;
    logic        rd_valid0, armed0, triggered0, done0;
    logic [31:0] rd_pc0, rd_inst0, rd_data0;
    logic [3:0]  count0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trace_capture #(.DEPTH(8), .POST(2), .W(32)) u_dut (
        .clk(clk), .reset(reset), .arm(arm), .trig_pc(trig_pc), .cap_valid(cap_valid),
        .cap_pc(cap_pc), .cap_inst(cap_inst), .cap_data(cap_data), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_data(rd_data),
        .count(count), .armed(armed), .triggered(triggered), .done(done)
    );

    trace_capture #(.DEPTH(8), .POST(0), .W(32)) u_dut0 (
        .clk(clk), .reset(reset), .arm(arm), .trig_pc(trig_pc), .cap_valid(cap_valid),
        .cap_pc(cap_pc), .cap_inst(cap_inst), .cap_data(cap_data), .rd_en(rd_en),
        .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_inst(rd_inst0), .rd_data(rd_data0),
        .count(count0), .armed(armed0), .triggered(triggered0), .done(done0)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [31:0] tpc);
        trig_pc = tpc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc);
        cap_valid = 1'b1;
        cap_pc    = pc;
        cap_inst  = inst_of(pc);
        cap_data  = data_of(pc);
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b0; cap_valid = 1'b0; rd_en = 1'b0;
        trig_pc = 32'h0; cap_pc = 32'h0; cap_inst = 32'h0; cap_data = 32'h0;
        tick();
        tick();
        vectors++;
        if ({rd_valid, armed, triggered, done, count} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 00000000", {rd_valid, armed, triggered, done, count});
        end
        vectors++;
        if ({rd_pc, rd_inst, rd_data} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_rd got %h exp 0", {rd_pc, rd_inst, rd_data});
        end
        vectors++;
        if ({rd_valid0, armed0, triggered0, done0, count0} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_flags_post0 got %b exp 00000000", {rd_valid0, armed0, triggered0, done0, count0});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_capture();
        do_arm(32'h3008);
        vectors++;
        if ({armed, triggered, done, count} !== {3'b100, 4'd0}) begin
            miscompares++;
            $display("FAIL armed_after_arm got %b exp 1000000", {armed, triggered, done, count});
        end
        commit(32'h3000);
        commit(32'h3004);
        commit(32'h3008);
        vectors++;
        if ({armed, triggered, done, count} !== {3'b010, 4'd3}) begin
            miscompares++;
            $display("FAIL post_after_trigger got %b exp 0100011", {armed, triggered, done, count});
        end
        commit(32'h300C);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_early got %b exp 0", done);
        end
        commit(32'h3010);
        vectors++;
        if ({armed, triggered, done, count} !== {3'b011, 4'd5}) begin
            miscompares++;
            $display("FAIL done_after_post got %b exp 0110101", {armed, triggered, done, count});
        end
        commit(32'h4000);
        vectors++;
        if (count !== 4'd5) begin
            miscompares++;
            $display("FAIL ignore_in_done got %0d exp 5", count);
        end
    endtask

    task automatic test_back_to_back_read();
        logic [31:0] exp_pc;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_pc = 32'h3000 + 32'(4 * i);
            vectors++;
            if ({rd_valid, rd_pc, rd_inst, rd_data} !== {1'b1, exp_pc, inst_of(exp_pc), data_of(exp_pc)}) begin
                miscompares++;
                $display("FAIL pop%0d got v=%b pc=%h inst=%h data=%h exp pc=%h", i, rd_valid, rd_pc, rd_inst, rd_data, exp_pc);
            end
        end
        vectors++;
        if (count !== 4'd0) begin
            miscompares++;
            $display("FAIL drained_count got %0d exp 0", count);
        end
        rd_en = 1'b0;
        tick();
        vectors++;
        if ({rd_valid, rd_pc} !== {1'b0, 32'h3010}) begin
            miscompares++;
            $display("FAIL rd_hold got v=%b pc=%h exp v=0 pc=00003010", rd_valid, rd_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        do_arm(32'h3024);
        for (int k = 0; k < 12; k++) begin
            commit(32'h3000 + 32'(4 * k));
            if (k == 10) begin
                vectors++;
                if ({triggered, done} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL wrap_k10_state got %b exp 10", {triggered, done});
                end
            end
        end
        vectors++;
        if ({done, count} !== {1'b1, 4'd8}) begin
            miscompares++;
            $display("FAIL wrap_done got done=%b count=%0d exp done=1 count=8", done, count);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_pc = 32'h3010 + 32'(4 * i);
            vectors++;
            if ({rd_valid, rd_pc} !== {1'b1, exp_pc}) begin
                miscompares++;
                $display("FAIL wrap_pop%0d got v=%b pc=%h exp v=1 pc=%h", i, rd_valid, rd_pc, exp_pc);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_post_zero_and_empty();
        do_arm(32'h3000);
        commit(32'h3000);
        vectors++;
        if ({triggered0, done0, count0} !== {2'b11, 4'd1}) begin
            miscompares++;
            $display("FAIL post0_done got %b exp 110001", {triggered0, done0, count0});
        end
        rd_en = 1'b1;
        tick();
        vectors++;
        if ({rd_valid0, rd_pc0, count0} !== {1'b1, 32'h3000, 4'd0}) begin
            miscompares++;
            $display("FAIL post0_pop got v=%b pc=%h count=%0d exp v=1 pc=00003000 count=0", rd_valid0, rd_pc0, count0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({rd_valid0, count0} !== {1'b0, 4'd0}) begin
                miscompares++;
                $display("FAIL empty_rd%0d got v=%b count=%0d exp v=0 count=0", i, rd_valid0, count0);
            end
        end
        rd_en = 1'b0;
        trig_pc = 32'h5000;
        arm = 1'b1;
        cap_valid = 1'b1; cap_pc = 32'h5000; cap_inst = inst_of(32'h5000); cap_data = data_of(32'h5000);
        tick();
        arm = 1'b0; cap_valid = 1'b0;
        vectors++;
        if ({armed0, done0, count0} !== {2'b10, 4'd0}) begin
            miscompares++;
            $display("FAIL arm_priority got %b exp 100000", {armed0, done0, count0});
        end
    endtask

    task automatic test_reset_mid_capture();
        do_arm(32'h3008);
        commit(32'h3000);
        commit(32'h3004);
        commit(32'h3008);
        vectors++;
        if ({triggered, done, count} !== {2'b10, 4'd3}) begin
            miscompares++;
            $display("FAIL pre_reset got %b exp 100011", {triggered, done, count});
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({rd_valid, armed, triggered, done, count, rd_pc} !== 40'h0) begin
            miscompares++;
            $display("FAIL async_reset got %h exp 0", {rd_valid, armed, triggered, done, count, rd_pc});
        end
        tick();
        reset = 1'b0;
        commit(32'h300C);
        vectors++;
        if ({armed, triggered, done, count} !== 7'h00) begin
            miscompares++;
            $display("FAIL idle_after_reset got %b exp 0000000", {armed, triggered, done, count});
        end
    endtask

    task automatic test_repeat_filter();
        logic [3:0] exp_cnt;
        do_arm(32'hFFFF_FFF0);
        commit(32'h3004);
        commit(32'h3004);
        commit(32'h3004);
`ifdef TRACE_REPEAT_FILTER_EN
        exp_cnt = 4'd1;
`else
        exp_cnt = 4'd3;
`endif
        vectors++;
        if (count !== exp_cnt) begin
            miscompares++;
            $display("FAIL repeat_count got %0d exp %0d", count, exp_cnt);
        end
        commit(32'h3008);
        exp_cnt = exp_cnt + 4'd1;
        vectors++;
        if (count !== exp_cnt) begin
            miscompares++;
            $display("FAIL repeat_then_new got %0d exp %0d", count, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_back_to_back_read();
        test_wrap();
        test_post_zero_and_empty();
        test_reset_mid_capture();
        test_repeat_filter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
